id_queue: RTL
=============

# id_queue

Parametrised decode stage with an elastic decoded-instruction queue between IF and EX. Each accepted `if_id_t` is decoded once on entry into a `decoded_t` word: fields, immediate, ALU/CMP selects and write-back mux select. The word is held in a DEPTH-entry FIFO and handed to EX over a valid/ready handshake. Register-file reads stay in EX. Fetch and execute stall independently, and flush clears the whole queue.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous flush (branch/jump redirect)
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  queue accepts this cycle
- in_pkt  in  if_id_t  pc, inst, valid
- out_valid  out  1  head entry available to EX
- out_ready  in  1  EX consumes head this cycle
- out_pkt  out  decoded_t  decoded head entry
- count  out  CNT_W  current occupancy

## Operation
- Enqueue when in_valid && in_ready && !flush && in_pkt.valid.
  - in_valid with in_pkt.valid=0 is consumed and discarded.
- Dequeue when out_valid && out_ready.
- Decode applied on enqueue:
  - Immediate per opcode: U for lui/auipc, J for jal, I for jalr/load/imm, B for br, S for store; 0 otherwise.
  - rd_s = 0 for store/br.
  - regf_we = 1 for load/lui/auipc/jal/jalr/imm/reg, forced 0 when rd_s==0.
  - alu_rs1_sel = 1 (PC) for auipc/jal/br.
  - alu_rs2_sel = 1 for every opcode except reg.
  - aluop: sub/sra from funct7[5] where applicable; add for slt/sltu.
  - cmpop: funct3 for br; blt/bltu for slt/sltu.
  - regfilemux_sel encodings: 0 ALU, 1 SLT, 2 imm, 3 LW, 4 PC+4, 5 LB, 6 LBU, 7 LH, 8 LHU.
  - illegal = 1 for an unknown opcode, or reg with funct7 ∉ {0x00,0x20}. Illegal entries are still queued; EX handles the trap.
- Pointers: head/tail are CNT_W bits. Full = MSBs differ and low bits equal; empty = pointers equal. Wrap is natural modulo 2·DEPTH.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so a full queue does not accept in the same cycle it dequeues.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Flush:
  - Next edge: head = tail = 0, count = 0.
  - In the flush cycle, out_valid is forced to 0 and the in_pkt is dropped.
  - Flush overrides both enqueue and dequeue.
- out_pkt = '0 whenever out_valid = 0.
- Reset (async assert) takes effect immediately: pointers 0, count 0, out_valid 0, out_pkt '0, in_ready 1 once rst_n is high. Storage array is not reset.

## Timing
- Latency in→out: 1 cycle. An entry enqueued at edge N is visible with out_valid from edge N onward.
- Throughput: 1 instruction/cycle in steady state with out_ready held high.
- out_valid and out_pkt come from registered state and flush only; no path from in_* to out_*.
- Reset deasserted mid-stream: the first enqueue is possible on the first rising edge with rst_n high.

## Configuration
- ID_QUEUE_BYPASS_EN defined:
  - When the queue is empty, in_valid && in_pkt.valid && out_ready && !flush, the decoded in_pkt appears on out_pkt with out_valid=1 in the same cycle. It is not written into the queue.
  - Latency becomes 0.
- Undefined: no in→out combinational path; behaviour exactly as in Operation.

## Structure
- Shared package rv32i_types gains:
  - decoded_t: pc, inst, opcode, funct3, funct7, rs1_s, rs2_s, rd_s, imm, alu_rs1_sel, alu_rs2_sel, aluop, cmpop, regf_we, regfilemux_sel[3:0], illegal.
  - Named constants for the regfilemux_sel encodings.
- Sub-module id_decoder: purely combinational, if_id_t in → decoded_t out. Instantiated once on the enqueue path; that path also feeds the bypass.

## Test plan
- Reset then enqueue 0x00500093 (addi x1,x0,5): next cycle out_valid=1, imm=5, rd_s=1, regf_we=1, alu_rs2_sel=1, regfilemux_sel=0; count=1.
- Enqueue 0x0020A423 (sw x2,8(x1)) and 0x00000063 (beq x0,x0,0): store gives imm=8, rd_s=0, regf_we=0; beq gives cmpop=beq, alu_rs1_sel=1.
- Hold out_ready=0 and push 5 instructions with DEPTH=4: in_ready drops after the 4th and count=4. Raise out_ready: entries drain in order, and pointers wrap correctly over 3 full refills.
- Queue holding 3 entries, assert flush together with in_valid: next cycle count=0, out_valid=0, and the flushed-cycle in_pkt is never output.
- Assert rst_n low mid-stream at count=2: out_valid=0 and count=0 immediately, without a clock edge.
- With ID_QUEUE_BYPASS_EN, empty queue and out_ready=1, enqueue 0x00500093: out_valid=1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/rv32i_types.sv
// RV32I shared types: fetch packet, decoded-instruction word, opcode/ALU/compare enums
// and write-back mux select encodings.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_e;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops_e;

  typedef enum logic [2:0] {
    cmp_beq  = 3'b000,
    cmp_bne  = 3'b001,
    cmp_blt  = 3'b100,
    cmp_bge  = 3'b101,
    cmp_bltu = 3'b110,
    cmp_bgeu = 3'b111
  } cmp_ops_e;

  localparam logic [3:0] RFM_ALU = 4'd0;
  localparam logic [3:0] RFM_SLT = 4'd1;
  localparam logic [3:0] RFM_IMM = 4'd2;
  localparam logic [3:0] RFM_LW  = 4'd3;
  localparam logic [3:0] RFM_PC4 = 4'd4;
  localparam logic [3:0] RFM_LB  = 4'd5;
  localparam logic [3:0] RFM_LBU = 4'd6;
  localparam logic [3:0] RFM_LH  = 4'd7;
  localparam logic [3:0] RFM_LHU = 4'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] imm;
    logic        alu_rs1_sel;
    logic        alu_rs2_sel;
    logic [2:0]  aluop;
    logic [2:0]  cmpop;
    logic        regf_we;
    logic [3:0]  regfilemux_sel;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: if_id_t -> decoded_t (fields, immediate, ALU/CMP and
// write-back selects). Zero latency, no handshake.
module id_decoder
  import rv32i_types::*;
(
  input  if_id_t   i_pkt,
  output decoded_t o_dec
);

  logic [31:0] w_inst;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_unused_valid;

  assign w_inst  = i_pkt.inst;
  assign w_f3    = w_inst[14:12];
  assign w_f7    = w_inst[31:25];
  assign w_imm_i = {{21{w_inst[31]}}, w_inst[30:20]};
  assign w_imm_s = {{21{w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
  assign w_imm_b = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'h000};
  assign w_imm_j = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_unused_valid = i_pkt.valid;

  always_comb begin
    o_dec             = '0;
    o_dec.pc          = i_pkt.pc;
    o_dec.inst        = w_inst;
    o_dec.opcode      = w_inst[6:0];
    o_dec.funct3      = w_f3;
    o_dec.funct7      = w_f7;
    o_dec.rs1_s       = w_inst[19:15];
    o_dec.rs2_s       = w_inst[24:20];
    o_dec.rd_s        = w_inst[11:7];
    o_dec.alu_rs2_sel = 1'b1;
    case (w_inst[6:0])
      op_lui:   begin o_dec.imm = w_imm_u; o_dec.regf_we = 1'b1; o_dec.regfilemux_sel = RFM_IMM; end
      op_auipc: begin o_dec.imm = w_imm_u; o_dec.regf_we = 1'b1; o_dec.alu_rs1_sel = 1'b1; end
      op_jal:   begin
        o_dec.imm = w_imm_j; o_dec.regf_we = 1'b1; o_dec.alu_rs1_sel = 1'b1;
        o_dec.regfilemux_sel = RFM_PC4;
      end
      op_jalr:  begin o_dec.imm = w_imm_i; o_dec.regf_we = 1'b1; o_dec.regfilemux_sel = RFM_PC4; end
      op_br:    begin
        o_dec.imm = w_imm_b; o_dec.rd_s = 5'd0; o_dec.alu_rs1_sel = 1'b1; o_dec.cmpop = w_f3;
      end
      op_store: begin o_dec.imm = w_imm_s; o_dec.rd_s = 5'd0; end
      op_load:  begin
        o_dec.imm = w_imm_i;
        o_dec.regf_we = 1'b1;
        case (w_f3)
          3'b000:  o_dec.regfilemux_sel = RFM_LB;
          3'b001:  o_dec.regfilemux_sel = RFM_LH;
          3'b100:  o_dec.regfilemux_sel = RFM_LBU;
          3'b101:  o_dec.regfilemux_sel = RFM_LHU;
          default: o_dec.regfilemux_sel = RFM_LW;
        endcase
      end
      op_imm, op_reg: begin
        o_dec.regf_we = 1'b1;
        if (w_inst[6:0] == op_reg) begin
          o_dec.alu_rs2_sel = 1'b0;
          o_dec.illegal     = (w_f7 != 7'h00) && (w_f7 != 7'h20);
        end else begin
          o_dec.imm = w_imm_i;
        end
        // slt/sltu resolve through the comparator; the ALU result is unused
        case (w_f3)
          3'b000:  o_dec.aluop = ((w_inst[6:0] == op_reg) && w_f7[5]) ? alu_sub : alu_add;
          3'b001:  o_dec.aluop = alu_sll;
          3'b010:  begin o_dec.cmpop = cmp_blt;  o_dec.regfilemux_sel = RFM_SLT; end
          3'b011:  begin o_dec.cmpop = cmp_bltu; o_dec.regfilemux_sel = RFM_SLT; end
          3'b100:  o_dec.aluop = alu_xor;
          3'b101:  o_dec.aluop = w_f7[5] ? alu_sra : alu_srl;
          3'b110:  o_dec.aluop = alu_or;
          default: o_dec.aluop = alu_and;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase
    if (o_dec.rd_s == 5'd0) o_dec.regf_we = 1'b0;
  end

endmodule

// File: rtl/id_queue.sv
// Decode-on-entry elastic queue between IF and EX; 1-cycle latency (0 with ID_QUEUE_BYPASS_EN
// on an empty queue); in_ready drops only when full, independent of out_ready; flush empties all.
module id_queue
  import rv32i_types::*;
#(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  if_id_t           in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output decoded_t         out_pkt,
  output logic [CNT_W-1:0] count
);

  localparam int AW = CNT_W - 1;

  logic [CNT_W-1:0] r_head, r_tail;
  decoded_t         r_mem [DEPTH];
  decoded_t         w_dec;
  logic             w_empty, w_full, w_enq, w_deq, w_byp;

  id_decoder u_dec (
    .i_pkt (in_pkt),
    .o_dec (w_dec)
  );

  assign w_empty  = (r_head == r_tail);
  assign w_full   = (r_head[AW] != r_tail[AW]) && (r_head[AW-1:0] == r_tail[AW-1:0]);
  assign count    = r_tail - r_head;
  assign in_ready = !w_full;

`ifdef ID_QUEUE_BYPASS_EN
  assign w_byp = w_empty && in_valid && in_pkt.valid && out_ready && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // Bypassed words go straight to EX and never occupy a slot
  assign w_enq = in_valid && in_ready && in_pkt.valid && !flush && !w_byp;
  assign w_deq = out_ready && !w_empty && !flush;

  always_comb begin
    out_valid = 1'b0;
    out_pkt   = '0;
    if (!flush && !w_empty) begin
      out_valid = 1'b1;
      out_pkt   = r_mem[r_head[AW-1:0]];
    end
`ifdef ID_QUEUE_BYPASS_EN
    else if (w_byp) begin
      out_valid = 1'b1;
      out_pkt   = w_dec;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + CNT_W'(1);
      if (w_deq) r_head <= r_head + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail[AW-1:0]] <= w_dec;
  end

endmodule
